// File: rtl/freq_meter_pkg.sv
// Shared definitions for the reciprocal frequency / duty / phase meter.
`timescale 1ns / 1ps

package freq_meter_pkg;

  // Default width of every result counter.
  localparam int unsigned CntWDefault = 32;

  // Default number of flops on each asynchronous input.
  localparam int unsigned SyncStagesDefault = 2;

  // Gate control states.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArm   = 3'd1,
    StMeas  = 3'd2,
    StClose = 3'd3,
    StDone  = 3'd4
  } state_e;

  // The real gate is open (counters run) only in these two states.
  function automatic logic is_counting(input state_e s);
    return (s == StMeas) || (s == StClose);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with rising-edge detect
// on the synchronised value.
`timescale 1ns / 1ps

module sync_edge
  import freq_meter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SyncStagesDefault
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   q_dly_q;

  // Shift the input through the synchroniser chain and keep a one-cycle delayed copy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      q_dly_q <= 1'b0;
    end else begin
      sync_q[0] <= d_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      q_dly_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = q_o & ~q_dly_q;

endmodule

// File: rtl/freq_meter_top.sv
// Equal-precision frequency meter core. A start command arms the gate; the real gate
// opens and closes on fx rising edges so it always spans whole fx periods. While it is
// open, fx edges, clk cycles, fx high time and fx-to-fxB lag are accumulated.
`timescale 1ns / 1ps

module freq_meter_top
  import freq_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = CntWDefault,
  parameter int unsigned SYNC_STAGES = SyncStagesDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_sig,
  input  logic             fx,
  input  logic             fxB,
  output logic [CNT_W-1:0] fx_cnt,
  output logic [CNT_W-1:0] fbase_cnt,
  output logic [CNT_W-1:0] time_cnt,
  output logic [CNT_W-1:0] duty_cnt,
  output logic             LED
);

  // Synchronised inputs.
  logic start_s, start_rise;
  logic fx_s, fx_rise;
  logic fxb_s, fxb_rise;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_start (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (start_sig),
    .q_o   (start_s),
    .rise_o(start_rise)
  );

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_fx (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (fx),
    .q_o   (fx_s),
    .rise_o(fx_rise)
  );

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_fxb (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (fxB),
    .q_o   (fxb_s),
    .rise_o(fxb_rise)
  );

  // Only the level of start and fxB matters; their edge detects are left idle.
  logic unused_rise;
  assign unused_rise = start_rise ^ fxb_rise;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  state_e state_q, state_d;
  logic   led_q, led_d;
  logic   clr;
  logic   cnt_en;

  logic [CNT_W-1:0] fx_cnt_q, fx_cnt_d;
  logic [CNT_W-1:0] fbase_cnt_q, fbase_cnt_d;
  logic [CNT_W-1:0] time_cnt_q, time_cnt_d;
  logic [CNT_W-1:0] duty_cnt_q, duty_cnt_d;

  // Gate control: next state, counter clear and LED.
  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    clr     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_s) state_d = StArm;
      end
      StArm: begin
        // First fx edge opens the gate; if start drops first, nothing is disturbed.
        if (fx_rise) begin
          clr     = 1'b1;
          led_d   = 1'b1;
          state_d = StMeas;
        end else if (!start_s) begin
          state_d = StIdle;
        end
      end
      StMeas: begin
        if (!start_s) state_d = StClose;
      end
      StClose: begin
        // Close on the next fx edge so the gate covers whole periods.
        if (fx_rise) begin
          led_d   = 1'b0;
          state_d = StDone;
        end
      end
      StDone: begin
        // Holds off a new gate until start has been seen low.
        if (!start_s) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign cnt_en = is_counting(state_q);

  // Counter next-state: clear on gate open, otherwise accumulate while the gate is open.
  always_comb begin
    fx_cnt_d    = fx_cnt_q;
    fbase_cnt_d = fbase_cnt_q;
    time_cnt_d  = time_cnt_q;
    duty_cnt_d  = duty_cnt_q;
    if (clr) begin
      fx_cnt_d    = '0;
      fbase_cnt_d = '0;
      time_cnt_d  = '0;
      duty_cnt_d  = '0;
    end else if (cnt_en) begin
      fbase_cnt_d = sat_inc(fbase_cnt_q);
      if (fx_rise) fx_cnt_d = sat_inc(fx_cnt_q);
      if (fx_s) duty_cnt_d = sat_inc(duty_cnt_q);
      if (fx_s && !fxb_s) time_cnt_d = sat_inc(time_cnt_q);
    end
  end

  // State, LED and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      led_q       <= 1'b0;
      fx_cnt_q    <= '0;
      fbase_cnt_q <= '0;
      time_cnt_q  <= '0;
      duty_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      led_q       <= led_d;
      fx_cnt_q    <= fx_cnt_d;
      fbase_cnt_q <= fbase_cnt_d;
      time_cnt_q  <= time_cnt_d;
      duty_cnt_q  <= duty_cnt_d;
    end
  end

  assign fx_cnt    = fx_cnt_q;
  assign fbase_cnt = fbase_cnt_q;
  assign time_cnt  = time_cnt_q;
  assign duty_cnt  = duty_cnt_q;
  assign LED       = led_q;

endmodule

// File: tb/tb_freq_meter_top.sv
// Directed bench: fx/fxB free-run at 1022 ns period, start is driven around known fx edges,
// expected ranges are queued when a scenario is launched and popped when results are sampled.
`timescale 1ns / 1ps

module tb_freq_meter_top;

  logic        clk;
  logic        rst;
  logic        start_sig;
  logic        fx;
  logic        fxB;
  logic [31:0] fx_cnt, fbase_cnt, time_cnt, duty_cnt;
  logic        led;
  logic [7:0]  s_fx_cnt, s_fbase_cnt, s_time_cnt, s_duty_cnt;
  logic        s_led;

  freq_meter_top #(
    .CNT_W      (32),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start_sig(start_sig),
    .fx       (fx),
    .fxB      (fxB),
    .fx_cnt   (fx_cnt),
    .fbase_cnt(fbase_cnt),
    .time_cnt (time_cnt),
    .duty_cnt (duty_cnt),
    .LED      (led)
  );

  // Narrow copy to exercise counter saturation within a short run.
  freq_meter_top #(
    .CNT_W      (8),
    .SYNC_STAGES(2)
  ) dut_sat (
    .clk      (clk),
    .rst      (rst),
    .start_sig(start_sig),
    .fx       (fx),
    .fxB      (fxB),
    .fx_cnt   (s_fx_cnt),
    .fbase_cnt(s_fbase_cnt),
    .time_cnt (s_time_cnt),
    .duty_cnt (s_duty_cnt),
    .LED      (s_led)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // fx: rises at 536 + 1022*k, high for 511 ns.
  initial begin
    fx = 1'b0;
    #536;
    forever begin
      fx = 1'b1;
      #511;
      fx = 1'b0;
      #511;
    end
  end

  // fxB: same waveform, 97 ns later.
  initial begin
    fxB = 1'b0;
    #633;
    forever begin
      fxB = 1'b1;
      #511;
      fxB = 1'b0;
      #511;
    end
  end

  typedef struct {
    string  tag;
    longint lo;
    longint hi;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic longint e(input int k);
    return 64'd536 + 64'd1022 * longint'(k);
  endfunction

  // Advance to absolute time t, then to the next falling clock edge.
  task automatic at(input longint t);
    if (t > longint'($time)) #(t - longint'($time));
    @(negedge clk);
  endtask

  task automatic expect_val(input string tag, input longint lo, input longint hi);
    exp_t x;
    x.tag = tag;
    x.lo  = lo;
    x.hi  = hi;
    sb.push_back(x);
  endtask

  task automatic expect_res(input string pfx, input longint fx_lo, input longint fx_hi,
                            input longint fb_lo, input longint fb_hi,
                            input longint du_lo, input longint du_hi,
                            input longint tm_lo, input longint tm_hi);
    expect_val({pfx, "_fx_cnt"}, fx_lo, fx_hi);
    expect_val({pfx, "_fbase_cnt"}, fb_lo, fb_hi);
    expect_val({pfx, "_duty_cnt"}, du_lo, du_hi);
    expect_val({pfx, "_time_cnt"}, tm_lo, tm_hi);
  endtask

  task automatic chk(input longint obs);
    exp_t x;
    n_total++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty: observed %0d with no expectation queued", obs);
    end else begin
      x = sb.pop_front();
      assert (obs >= x.lo && obs <= x.hi) n_pass++;
      else $error("FAIL %s: observed %0d, expected %0d..%0d", x.tag, obs, x.lo, x.hi);
    end
  endtask

  task automatic chk_res();
    chk(longint'(fx_cnt));
    chk(longint'(fbase_cnt));
    chk(longint'(duty_cnt));
    chk(longint'(time_cnt));
  endtask

  initial begin
    rst       = 1'b1;
    start_sig = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Reset state.
    expect_val("rst_led", 0, 0);
    expect_res("rst", 0, 0, 0, 0, 0, 0, 0, 0);
    chk(longint'(led));
    chk_res();

    // Idle with fx toggling: nothing moves.
    expect_val("idle_led", 0, 0);
    expect_res("idle", 0, 0, 0, 0, 0, 0, 0, 0);
    at(1200);
    chk(longint'(led));
    chk_res();

    // One-period gate: start high from 363 ns before to 440 ns after an fx edge.
    at(e(2) - 363);
    start_sig = 1'b1;
    expect_val("one_led_open", 1, 1);
    expect_val("one_led_closed", 0, 0);
    expect_res("one", 1, 1, 50, 52, 24, 27, 4, 6);
    at(e(2) + 440);
    start_sig = 1'b0;
    at(e(2) + 500);
    chk(longint'(led));
    at(e(3) + 150);
    chk(longint'(led));
    chk_res();

    // Ten-period gate, also saturating the 8-bit copy.
    at(e(5) - 363);
    start_sig = 1'b1;
    expect_val("ten_led_open", 1, 1);
    expect_res("ten", 10, 10, 510, 512, 252, 258, 46, 51);
    expect_val("sat_fx_cnt", 10, 10);
    expect_val("sat_fbase_cnt", 255, 255);
    expect_val("sat_duty_cnt", 252, 255);
    at(e(10));
    chk(longint'(led));
    at(e(5) - 363 + 10000);
    start_sig = 1'b0;
    at(e(15) + 200);
    chk_res();
    chk(longint'(s_fx_cnt));
    chk(longint'(s_fbase_cnt));
    chk(longint'(s_duty_cnt));

    // Start pulse between fx edges: falls back to idle, results untouched.
    at(e(16) + 100);
    start_sig = 1'b1;
    expect_val("abort_led", 0, 0);
    expect_val("abort_fx_cnt", 10, 10);
    expect_val("abort_fbase_cnt", 510, 512);
    at(e(16) + 300);
    start_sig = 1'b0;
    at(e(17) + 200);
    chk(longint'(led));
    chk(longint'(fx_cnt));
    chk(longint'(fbase_cnt));

    // 200 ns start pulse straddling an fx edge: still a full one-period gate.
    at(e(18) - 100);
    start_sig = 1'b1;
    expect_val("pulse_led_open", 1, 1);
    expect_val("pulse_led_closed", 0, 0);
    expect_res("pulse", 1, 1, 50, 52, 24, 27, 4, 6);
    at(e(18) + 100);
    start_sig = 1'b0;
    at(e(18) + 400);
    chk(longint'(led));
    at(e(19) + 200);
    chk(longint'(led));
    chk_res();

    // Start re-raised during close: gate ends normally, no new gate until start cycles low.
    at(e(20) - 363);
    start_sig = 1'b1;
    expect_val("reraise_led", 0, 0);
    expect_res("reraise", 1, 1, 50, 52, 24, 27, 4, 6);
    expect_val("hold_led", 0, 0);
    expect_val("hold_fx_cnt", 1, 1);
    expect_val("hold_fbase_cnt", 50, 52);
    expect_val("hold2_fx_cnt", 1, 1);
    at(e(20) + 440);
    start_sig = 1'b0;
    at(e(20) + 700);
    start_sig = 1'b1;
    at(e(21) + 200);
    chk(longint'(led));
    chk_res();
    at(e(22) + 200);
    chk(longint'(led));
    chk(longint'(fx_cnt));
    chk(longint'(fbase_cnt));
    at(e(23) + 200);
    chk(longint'(fx_cnt));

    // Start low then high again: a fresh gate opens and clears the results.
    at(e(23) + 300);
    start_sig = 1'b0;
    at(e(23) + 600);
    start_sig = 1'b1;
    expect_val("new_led", 1, 1);
    expect_val("new_fx_cnt", 0, 0);
    at(e(24) + 300);
    chk(longint'(led));
    chk(longint'(fx_cnt));

    // Reset in the middle of a gate.
    at(e(24) + 500);
    start_sig = 1'b0;
    rst       = 1'b1;
    expect_val("mid_rst_led", 0, 0);
    expect_res("mid_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    expect_val("post_rst_led", 0, 0);
    expect_val("post_rst_fx_cnt", 0, 0);
    expect_val("post_rst_fbase_cnt", 0, 0);
    @(negedge clk);
    rst = 1'b0;
    chk(longint'(led));
    chk_res();
    at(e(26) + 200);
    chk(longint'(led));
    chk(longint'(fx_cnt));
    chk(longint'(fbase_cnt));

    if (sb.size() != 0) begin
      n_total++;
      $error("FAIL scoreboard_leftover: observed %0d entries, expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
